// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-port signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ready_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ready_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              owner_o;
  logic              busy_o;

  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ready_i, mem_rdata_i,
    output if_ready_o, if_rdata_o, dm_ready_o, dm_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, owner_o, busy_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ready_i, mem_rdata_i,
    input  if_ready_o, if_rdata_o, dm_ready_o, dm_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, owner_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for one shared variable-latency memory port
// Optional IF anti-starvation streak counter enabled by defining ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              any_req;
  logic              grant_dm;

`ifdef ARB_FAIRNESS_EN
  localparam int STREAK_W = $clog2(STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STREAK_MAX);

  logic [STREAK_W-1:0] streak_q, streak_d;

  // After STREAK_MAX contested DM wins in a row, the next contest goes to IF.
  assign grant_dm = bus.dm_req_i && !(bus.if_req_i && (streak_q == STREAK_TOP));

  always_comb begin
    streak_d = streak_q;
    if (state_q == ST_IDLE) begin
      if (!bus.if_req_i) begin
        streak_d = '0;
      end else if (grant_dm) begin
        streak_d = (streak_q == STREAK_TOP) ? streak_q : streak_q + 1'b1;
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign grant_dm = bus.dm_req_i;
`endif

  assign any_req = bus.if_req_i || bus.dm_req_i;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b1;
          busy_d    = 1'b1;
          owner_d   = grant_dm;
          if (grant_dm) begin
            mem_we_d    = bus.dm_we_i;
            mem_addr_d  = bus.dm_addr_i;
            mem_wdata_d = bus.dm_wdata_i;
          end else begin
            // Fetches never write; the previous store data is left in place.
            mem_we_d   = 1'b0;
            mem_addr_d = bus.if_addr_i;
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_ready_i) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          if (owner_q) begin
            dm_ready_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = bus.mem_rdata_i;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = bus.mem_rdata_i;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_ready_o  = if_ready_q;
  assign bus.dm_ready_o  = dm_ready_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  assign bus.owner_o     = owner_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STREAK_MAX(4)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [139:0] all_outs();
    return {bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o,
            bus.if_ready_o, bus.dm_ready_o, bus.if_rdata_o, bus.dm_rdata_o,
            bus.owner_o, bus.busy_o};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", all_outs());
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.mem_req_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle req=%b busy=%b want 0 0", bus.mem_req_o, bus.busy_o);
    end
  endtask

  task automatic test_single_fetch();
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 32'h10;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'hDEADBEEF;
    checks++;
    if (bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL fetch_c0_req got %b want 0", bus.mem_req_o);
    end
    tick();
    checks++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.owner_o, bus.busy_o, bus.if_ready_o}
        !== {1'b1, 1'b0, 32'h10, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL fetch_c1 req=%b we=%b addr=%h own=%b busy=%b rdy=%b want 1 0 10 0 1 0",
               bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.owner_o, bus.busy_o, bus.if_ready_o);
    end
    tick();
    checks++;
    if ({bus.if_ready_o, bus.dm_ready_o, bus.mem_req_o, bus.busy_o, bus.if_rdata_o}
        !== {1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL fetch_c2 ifr=%b dmr=%b req=%b busy=%b rdata=%h want 1 0 0 1 deadbeef",
               bus.if_ready_o, bus.dm_ready_o, bus.mem_req_o, bus.busy_o, bus.if_rdata_o);
    end
    bus.if_req_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = 32'h0BAD0BAD;
    tick();
    checks++;
    if ({bus.if_ready_o, bus.busy_o, bus.if_rdata_o} !== {1'b0, 1'b0, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL fetch_c3 ifr=%b busy=%b rdata=%h want 0 0 deadbeef",
               bus.if_ready_o, bus.busy_o, bus.if_rdata_o);
    end
  endtask

  task automatic test_store_wait();
    int pulses;
    pulses = 0;
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = 1'b1;
    bus.dm_addr_i  = 32'h40;
    bus.dm_wdata_i = 32'h1234;
    tick();
    for (int i = 0; i < 3; i++) begin
      pulses += int'(bus.dm_ready_o);
      checks++;
      if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.owner_o}
          !== {1'b1, 1'b1, 32'h40, 32'h1234, 1'b1}) begin
        errors++;
        $display("FAIL store_wait%0d req=%b we=%b addr=%h wdata=%h own=%b want 1 1 40 1234 1",
                 i, bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.owner_o);
      end
      bus.dm_addr_i = 32'hFFFF_0000 + i;
      tick();
    end
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h5555AAAA;
    tick();
    pulses += int'(bus.dm_ready_o);
    checks++;
    if ({bus.dm_ready_o, bus.if_ready_o, bus.dm_rdata_o, bus.mem_req_o}
        !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL store_done dmr=%b ifr=%b dmrdata=%h req=%b want 1 0 0 0",
               bus.dm_ready_o, bus.if_ready_o, bus.dm_rdata_o, bus.mem_req_o);
    end
    bus.dm_req_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    tick();
    pulses += int'(bus.dm_ready_o);
    tick();
    pulses += int'(bus.dm_ready_o);
    checks++;
    if (pulses !== 1 || bus.owner_o !== 1'b1) begin
      errors++;
      $display("FAIL store_pulses got %0d owner=%b want 1 1", pulses, bus.owner_o);
    end
  endtask

  task automatic test_contention();
    logic [5:0] exp_dm;
    logic [5:0] got_dm;
`ifdef ARB_FAIRNESS_EN
    exp_dm = 6'b101111;
`else
    exp_dm = 6'b111111;
`endif
    got_dm = '0;
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 32'h100;
    bus.dm_req_i    = 1'b1;
    bus.dm_we_i     = 1'b0;
    bus.dm_addr_i   = 32'h200;
    bus.mem_ready_i = 1'b1;
    for (int t = 0; t < 6; t++) begin
      bus.mem_rdata_i = 32'hC0DE_0000 + t;
      tick();
      got_dm[t] = bus.owner_o;
      tick();
      checks++;
      if ({bus.dm_ready_o, bus.if_ready_o} !== {exp_dm[t], ~exp_dm[t]}) begin
        errors++;
        $display("FAIL contention_ready%0d dmr=%b ifr=%b want %b %b",
                 t, bus.dm_ready_o, bus.if_ready_o, exp_dm[t], ~exp_dm[t]);
      end
      checks++;
      if ((exp_dm[t] ? bus.dm_rdata_o : bus.if_rdata_o) !== 32'hC0DE_0000 + t) begin
        errors++;
        $display("FAIL contention_rdata%0d got %h want %h", t,
                 exp_dm[t] ? bus.dm_rdata_o : bus.if_rdata_o, 32'hC0DE_0000 + t);
      end
      tick();
    end
    checks++;
    if (got_dm !== exp_dm) begin
      errors++;
      $display("FAIL contention_order got %b want %b", got_dm, exp_dm);
    end
    bus.if_req_i    = 1'b0;
    bus.dm_req_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bus.dm_req_i  = 1'b1;
    bus.dm_we_i   = 1'b0;
    bus.dm_addr_i = 32'h300;
    tick();
    checks++;
    if (bus.mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_wait req got %b want 1", bus.mem_req_o);
    end
    rst_n        = 1'b0;
    bus.dm_req_i = 1'b0;
    tick();
    rst_n           = 1'b1;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'hFEEDFACE;
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got %h want 0", all_outs());
    end
    tick();
    tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++;
      $display("FAIL midrst_late_ready got %h want 0", all_outs());
    end
    bus.mem_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic exp;
    bus.if_req_i    = 1'b1;
    bus.if_addr_i   = 32'h20;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h600DF00D;
    for (int c = 0; c < 8; c++) begin
      exp = (c == 2) || (c == 5);
      checks++;
      if (bus.if_ready_o !== exp) begin
        errors++;
        $display("FAIL b2b_cycle%0d if_ready got %b want %b", c, bus.if_ready_o, exp);
      end
      tick();
    end
    bus.if_req_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = '0;
    bus.dm_req_i    = 1'b0;
    bus.dm_we_i     = 1'b0;
    bus.dm_addr_i   = '0;
    bus.dm_wdata_i  = '0;
    bus.mem_ready_i = 1'b0;
    bus.mem_rdata_i = '0;
    #1;
    test_reset();
    test_single_fetch();
    test_store_wait();
    test_contention();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
